// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the L1 cache port arbiter.
// Default geometry matches the header.vh Rom_base/Ram_base layout.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int          DEFAULT_DEPTH        = 3072;
  localparam int          DEFAULT_AW           = 12;
  localparam logic [63:0] DEFAULT_BASE         = 64'h0;
  localparam int          DEFAULT_STARVE_LIMIT = 4;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/cache_addr_check.sv
// Byte address to BRAM word index conversion with range and alignment check.
module cache_addr_check
  import cache_arb_pkg::*;
#(
  parameter int          DEPTH = DEFAULT_DEPTH,
  parameter int          AW    = DEFAULT_AW,
  parameter logic [63:0] BASE  = DEFAULT_BASE
) (
  input  logic [63:0]   addr,
  output logic [AW-1:0] idx,
  output logic          ok
);

  logic [64:0] diff;
  logic [63:0] word_off;

  // The extra MSB catches addr < BASE as a borrow instead of a wrapped offset.
  always_comb begin
    diff     = {1'b0, addr} - {1'b0, BASE};
    word_off = diff[63:0] >> 2;
    idx      = word_off[AW-1:0];
    ok       = !diff[64] && (word_off < 64'(DEPTH)) && (addr[1:0] == 2'b00);
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Arbitrates fetch and data requesters onto the single-port L1 BRAM.
// Data wins ties until fetch has waited STARVE_LIMIT data grants.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int          DEPTH        = DEFAULT_DEPTH,
  parameter int          AW           = DEFAULT_AW,
  parameter logic [63:0] BASE         = DEFAULT_BASE,
  parameter int          STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter bit          IF_SWAP      = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [63:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [63:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [AW-1:0] if_idx, d_idx;
  logic          if_ok, d_ok;

  cache_addr_check #(.DEPTH(DEPTH), .AW(AW), .BASE(BASE)) u_if_check (
    .addr (if_addr),
    .idx  (if_idx),
    .ok   (if_ok)
  );

  cache_addr_check #(.DEPTH(DEPTH), .AW(AW), .BASE(BASE)) u_d_check (
    .addr (d_addr),
    .idx  (d_idx),
    .ok   (d_ok)
  );

  logic [SW-1:0] starve_q, starve_d;
  owner_e        own_q, own_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic          grant_if, grant_d;

  always_comb begin
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    starve_d  = starve_q;
    own_d     = OWN_NONE;
    err_d     = 1'b0;
    we_d      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = d_idx;
    mem_wdata = d_wdata;

    // Grants stay low through reset so nothing reaches the BRAM.
    if (reset_n) begin
      if (if_req && (!d_req || starve_q == STARVE_MAX)) begin
        grant_if = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end

    if (!if_req || grant_if) begin
      starve_d = '0;
    end else if (grant_d && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end

    if (grant_if) begin
      own_d    = OWN_IF;
      err_d    = !if_ok;
      mem_en   = if_ok;
      mem_addr = if_idx;
    end else if (grant_d) begin
      own_d  = OWN_D;
      err_d  = !d_ok;
      we_d   = d_we;
      mem_en = d_ok;
      mem_we = d_ok && d_we;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      own_q    <= OWN_NONE;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      own_q    <= own_d;
      err_q    <= err_d;
      we_q     <= we_d;
      starve_q <= starve_d;
    end
  end

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign if_rvalid = (own_q == OWN_IF);
  assign d_rvalid  = (own_q == OWN_D);
  assign if_err    = if_rvalid && err_q;
  assign d_err     = d_rvalid && err_q;

  // Stale BRAM output is masked so errors and write acks always return zero.
  assign if_rdata = (if_rvalid && !err_q) ? (IF_SWAP ? bswap32(mem_rdata) : mem_rdata) : '0;
  assign d_rdata  = (d_rvalid && !err_q && !we_q) ? mem_rdata : '0;

endmodule
